// File: rtl/mac_result_drain_pkg.sv
// Shared types and helpers for the MAC row result drain.
package mac_pkg;

  localparam int ACC_W = 26;
  // Working width for the shift/saturate helper. Wide enough for any lane accumulator.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {IDLE, RUN, SETTLE, DRAIN} drain_state_e;

  // Floor arithmetic right shift, then clamp into a signed out_w-bit range.
  // Shifts at or beyond the source width collapse to 0 or -1 through sign extension.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] x,
    input logic        [4:0]       sh,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] s, hi, lo;
    s  = x >>> sh;
    hi = '0;
    for (int b = 0; b < SAT_W; b++) hi[b] = (b < out_w - 1);
    lo = ~hi;
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// Result stream: one lane result per beat, valid/ready handshake.
interface mac_result_drain_if #(
  parameter int OUT_W  = 16,
  parameter int LANE_W = 2
);
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic        [LANE_W-1:0] out_lane;
  logic                     out_last;

  modport master (output out_valid, out_data, out_lane, out_last, input  out_ready);
  modport slave  (input  out_valid, out_data, out_lane, out_last, output out_ready);
endinterface

// File: rtl/mac_result_drain_fmt.sv
// Combinational result formatter: arithmetic shift then signed saturation.
module mac_result_fmt
  import mac_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  x,
  input  logic        [4:0]       sh,
  output logic signed [OUT_W-1:0] y
);

  logic signed [SAT_W-1:0] wide;

  // Sign-extend into the helper width; the saturated value always fits OUT_W.
  always_comb begin
    wide = sat_shift(SAT_W'(x), sh, OUT_W);
    y    = wide[OUT_W-1:0];
  end

endmodule

// File: rtl/mac_result_drain.sv
// Pulse controller and result readout for one row of MAC lanes.
// A run is the difference between accumulator snapshots taken before and after
// the pulses, so lane accumulators never need clearing between runs.
module mac_result_drain #(
  parameter int NUM_LANES = 4,
  parameter int ACC_W     = mac_pkg::ACC_W,
  parameter int OUT_W     = 16,
  parameter int K_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [K_W-1:0]             k_steps,
  input  logic [4:0]                 shift,
  input  logic [NUM_LANES*ACC_W-1:0] acc_in,
  output logic                       pulse,
  output logic                       busy,
  output logic                       done,
  mac_result_drain_if.master         ob
);

  localparam int LANE_W = $clog2(NUM_LANES);

  mac_pkg::drain_state_e state_q, state_d;

  logic [K_W-1:0]                      cnt_q;
  logic [4:0]                          sh_q;
  logic [LANE_W-1:0]                   idx_q;
  logic [NUM_LANES-1:0][ACC_W-1:0]     base_q;
  logic [NUM_LANES-1:0][ACC_W-1:0]     delta_q;
  logic [ACC_W-1:0]                    sel_delta;
  logic signed [OUT_W-1:0]             fmt_y;
  logic                                valid, last, hs, take;

  assign take  = (state_q == mac_pkg::IDLE) && start;
  assign valid = (state_q == mac_pkg::DRAIN);
  assign last  = (idx_q == LANE_W'(NUM_LANES - 1));
  assign hs    = valid && ob.out_ready;
  assign busy  = (state_q != mac_pkg::IDLE);

  // State register; reset aborts any run in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= mac_pkg::IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic. A zero-length run skips RUN and goes straight to SETTLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      mac_pkg::IDLE:   if (start) state_d = (k_steps != '0) ? mac_pkg::RUN : mac_pkg::SETTLE;
      mac_pkg::RUN:    if (cnt_q == K_W'(1)) state_d = mac_pkg::SETTLE;
      mac_pkg::SETTLE: state_d = mac_pkg::DRAIN;
      mac_pkg::DRAIN:  if (ob.out_ready && last) state_d = mac_pkg::IDLE;
      default:         state_d = mac_pkg::IDLE;
    endcase
  end

  // Control registers: registered pulse, step counter, shift, drain index, done strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse <= 1'b0;
      done  <= 1'b0;
      cnt_q <= '0;
      sh_q  <= '0;
      idx_q <= '0;
    end else begin
      pulse <= (state_d == mac_pkg::RUN);
      done  <= hs && last;
      if (take) begin
        cnt_q <= k_steps;
        sh_q  <= shift;
      end else if (state_q == mac_pkg::RUN) begin
        cnt_q <= cnt_q - K_W'(1);
      end
      if (state_q == mac_pkg::SETTLE) idx_q <= '0;
      else if (hs)                    idx_q <= last ? '0 : idx_q + LANE_W'(1);
    end
  end

  // Per-lane snapshots: base at start, modular run delta once the last update has landed.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        base_q[i]  <= '0;
        delta_q[i] <= '0;
      end else begin
        if (take) base_q[i] <= acc_in[i*ACC_W +: ACC_W];
        if (state_q == mac_pkg::SETTLE) delta_q[i] <= acc_in[i*ACC_W +: ACC_W] - base_q[i];
      end
    end
  end

  assign sel_delta = delta_q[idx_q];

  mac_result_fmt #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_fmt (
    .x  (sel_delta),
    .sh (sh_q),
    .y  (fmt_y)
  );

  // Outputs are a function of registered state only, so they hold under backpressure.
  assign ob.out_valid = valid;
  assign ob.out_data  = valid ? fmt_y : '0;
  assign ob.out_lane  = idx_q;
  assign ob.out_last  = valid && last;

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain: lanes modelled as accumulators that
// add a per-lane product sum on every pulse, or driven directly with chosen values.
module tb_mac_result_drain;

  localparam int NL = 4;
  localparam int AW = 26;
  localparam int OW = 16;
  localparam int KW = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [KW-1:0]     k_steps = '0;
  logic [4:0]        shift = '0;
  logic [NL*AW-1:0]  acc_in;
  logic              pulse, busy, done;

  mac_result_drain_if #(.OUT_W(OW), .LANE_W(2)) ob ();

  mac_result_drain #(.NUM_LANES(NL), .ACC_W(AW), .OUT_W(OW), .K_W(KW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .k_steps (k_steps),
    .shift   (shift),
    .acc_in  (acc_in),
    .pulse   (pulse),
    .busy    (busy),
    .done    (done),
    .ob      (ob)
  );

  always #5 clk = ~clk;

  // Lane model: each pulse-high cycle adds step[i] (a1*b1 + a2*b2) at the closing edge.
  logic signed [AW-1:0] acc_mac [NL];
  logic signed [AW-1:0] acc_ovr [NL];
  logic signed [AW-1:0] ovr_after [NL];
  logic signed [AW-1:0] step [NL];
  logic                 use_ovr = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) for (int i = 0; i < NL; i++) acc_mac[i] <= '0;
    else if (pulse) for (int i = 0; i < NL; i++) acc_mac[i] <= acc_mac[i] + step[i];
  end

  always_comb begin
    acc_in = '0;
    for (int i = 0; i < NL; i++) acc_in[i*AW +: AW] = use_ovr ? acc_ovr[i] : acc_mac[i];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: run result is the accumulator change taken modulo 2^26 as signed,
  // then floor-divided by 2^sh and clamped into the 16-bit signed range.
  function automatic longint wrap26(input longint v);
    longint m;
    m = v % 64'sd67108864;
    if (m < 0) m += 64'sd67108864;
    if (m >= 64'sd33554432) m -= 64'sd67108864;
    return m;
  endfunction

  function automatic longint fmt_ref(input longint d, input int sh);
    longint p, q;
    p = longint'(1) << sh;
    if (d >= 0) q = d / p;
    else        q = -((-d + p - 1) / p);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  longint exp_q [NL];
  int     stall_lane = -1;
  int     stall_n = 0;
  bit     rnd_rdy = 1'b0;

  // One complete run: start, count pulses, consume beats, check latency and done.
  task automatic do_run(input int k, input int sh);
    int n, pulses, first, beat, stalls;
    bit held, rdy;
    logic signed [OW-1:0] pd;
    logic [1:0] pl;
    n = 0; pulses = 0; first = -1; beat = 0; stalls = 0; held = 0; pd = '0; pl = '0;
    @(negedge clk);
    start = 1'b1; k_steps = KW'(k); shift = 5'(sh); ob.out_ready = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    if (use_ovr) for (int i = 0; i < NL; i++) acc_ovr[i] = ovr_after[i];
    while (beat < NL && n < k + 300) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (pulse) pulses++;
      if (ob.out_valid) begin
        if (first < 0) first = n;
        if (held) begin
          chk("hold_data", ob.out_data, pd);
          chk("hold_lane", ob.out_lane, pl);
        end
        rdy = 1'b1;
        if (beat == stall_lane && stalls < stall_n) begin
          rdy = 1'b0;
          stalls++;
          if (stalls == 1) start = 1'b1;   // must be ignored while busy
        end else if (rnd_rdy) begin
          rdy = ($urandom_range(0, 2) != 0);
        end
        ob.out_ready = rdy;
        if (rdy) begin
          chk("lane", ob.out_lane, beat);
          chk("data", ob.out_data, exp_q[beat]);
          chk("last", ob.out_last, (beat == NL - 1));
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          pd = ob.out_data;
          pl = ob.out_lane;
        end
      end else begin
        ob.out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (beat < NL) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: got %0d beats expected %0d", beat, NL);
    end
    @(negedge clk);
    ob.out_ready = 1'b0;
    chk("done_strobe", done, 1);
    chk("idle_busy", busy, 0);
    chk("idle_valid", ob.out_valid, 0);
    @(negedge clk);
    chk("done_single", done, 0);
    chk("pulse_count", pulses, k);
    chk("latency", first, k + 2);
  endtask

  typedef struct packed {
    logic [NL-1:0][AW-1:0] base;
    logic [NL-1:0][AW-1:0] after;
    logic [NL-1:0][31:0]   exp;
    int                    sh;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int pc, k, sh;
    // Directly driven snapshots: saturation, shift flooring, wrap and large shifts.
    tbl[0].base  = '0;
    tbl[0].after = {26'(-5), 26'(5), 26'(-100000), 26'(40000)};
    tbl[0].exp   = {32'(-5), 32'(5), 32'(-32768), 32'(32767)};
    tbl[0].sh    = 0;
    tbl[1].base  = '0;
    tbl[1].after = {26'(-5), 26'(5), 26'(-100000), 26'(40000)};
    tbl[1].exp   = {32'(-2), 32'(1), 32'(-25000), 32'(10000)};
    tbl[1].sh    = 2;
    tbl[2].base  = {26'(0), 26'(7), 26'(-1000), 26'(33554431)};
    tbl[2].after = {26'(-3000000), 26'(6), 26'(1000), 26'(-33554432)};
    tbl[2].exp   = {32'(-1), 32'(-1), 32'(0), 32'(0)};
    tbl[2].sh    = 31;
    tbl[3].base  = {4{26'd100}};
    tbl[3].after = {26'(100 - 32769), 26'(100 + 32768), 26'(100 - 32768), 26'(100 + 32767)};
    tbl[3].exp   = {32'(-32768), 32'(32767), 32'(-32768), 32'(32767)};
    tbl[3].sh    = 0;
    tbl[4].base  = '0;
    tbl[4].after = {26'(-524288), 26'(524288), 26'(-524289), 26'(524287)};
    tbl[4].exp   = {32'(-32768), 32'(32767), 32'(-32768), 32'(32767)};
    tbl[4].sh    = 4;

    for (int i = 0; i < NL; i++) begin
      step[i] = '0; acc_ovr[i] = '0; ovr_after[i] = '0;
    end
    ob.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pulse", pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", ob.out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_last", ob.out_last, 0);
    chk("rst_data", ob.out_data, 0);
    chk("rst_lane", ob.out_lane, 0);
    reset_n = 1'b1;

    // Basic run: 2*3 + (-1)*4 = 2 per pulse, five pulses
    for (int i = 0; i < NL; i++) begin step[i] = 26'sd2; exp_q[i] = 10; end
    do_run(5, 0);
    // Same run again: accumulators go 10 -> 20, result still 10
    do_run(5, 0);
    // Zero-length run
    for (int i = 0; i < NL; i++) exp_q[i] = 0;
    do_run(0, 0);
    // Backpressure on lane 1 with a start poke during DRAIN
    for (int i = 0; i < NL; i++) exp_q[i] = 10;
    stall_lane = 1; stall_n = 3;
    do_run(5, 0);
    stall_lane = -1; stall_n = 0;

    // Table-driven snapshots
    use_ovr = 1'b1;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NL; i++) begin
        acc_ovr[i]   = tbl[r].base[i];
        ovr_after[i] = tbl[r].after[i];
        exp_q[i]     = longint'($signed(tbl[r].exp[i]));
      end
      do_run(r + 1, tbl[r].sh);
    end
    use_ovr = 1'b0;

    // Reset during RUN at the third of eight pulses
    @(negedge clk);
    start = 1'b1; k_steps = KW'(8); shift = '0;
    @(posedge clk);
    #1 start = 1'b0;
    pc = 0;
    for (int c = 0; c < 20 && pc < 3; c++) begin
      @(negedge clk);
      if (pulse) pc++;
    end
    chk("mid_pulses_seen", pc, 3);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_pulse", pulse, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", ob.out_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_idle", busy, 0);
    for (int i = 0; i < NL; i++) exp_q[i] = 10;
    do_run(5, 0);

    // Randomized runs against the reference
    rnd_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      k  = $urandom_range(0, 12);
      sh = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 6);
      use_ovr = 1'($urandom_range(0, 1));
      for (int i = 0; i < NL; i++) begin
        int s;
        s = int'($urandom_range(0, 16777215)) - 8388608;
        step[i]      = AW'(s);
        acc_ovr[i]   = AW'($urandom);
        ovr_after[i] = AW'($urandom);
        if (use_ovr) exp_q[i] = fmt_ref(wrap26(longint'(ovr_after[i]) - longint'(acc_ovr[i])), sh);
        else         exp_q[i] = fmt_ref(wrap26(longint'(k) * longint'(step[i])), sh);
      end
      do_run(k, sh);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
